// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the SIPO receiver: bit-order codes and FSM states.
package sipo_rx_pkg;

    localparam logic DIR_MSB_FIRST = 1'b1;
    localparam logic DIR_LSB_FIRST = 1'b0;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/sipo_out_buf.sv
// Single-entry valid/ready output register with a sticky overflow flag.
module sipo_out_buf
    import sipo_rx_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] word,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         overflow
);

    logic free;

    // A consume in the same cycle frees the slot for a refill, no bubble.
    assign free = !dout_valid || dout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (load) begin
            if (free) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else begin
                overflow   <= 1'b1;
            end
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: assembles N-bit words in either bit
// order and hands them to a single-entry valid/ready output register.
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 direction,
    input  logic                 din,
    input  logic                 din_valid,
    output logic [N-1:0]         dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 busy,
    output logic [$clog2(N)-1:0] bit_cnt,
    output logic                 overflow
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt_nx;
    logic [N-1:0]  sr;
    logic [N-1:0]  sr_nx;
    logic          dir_q;
    logic          dir_nx;
    logic          eff_dir;
    logic          complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            sr      <= '0;
            dir_q   <= DIR_LSB_FIRST;
        end else begin
            state   <= state_nx;
            bit_cnt <= cnt_nx;
            sr      <= sr_nx;
            dir_q   <= dir_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = bit_cnt;
        sr_nx    = sr;
        dir_nx   = dir_q;
        complete = 1'b0;
        // The first bit of a word uses the live direction input.
        eff_dir  = (state == S_IDLE) ? direction : dir_q;
        if (clear) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end else if (din_valid) begin
            if (eff_dir == DIR_MSB_FIRST)
                sr_nx = {sr[N-2:0], din};
            else
                sr_nx = {din, sr[N-1:1]};
            if (state == S_IDLE)
                dir_nx = direction;
            if (bit_cnt == LAST) begin
                complete = 1'b1;
                cnt_nx   = '0;
                state_nx = S_IDLE;
            end else begin
                cnt_nx   = bit_cnt + CW'(1);
                state_nx = S_SHIFT;
            end
        end
    end

    assign busy = (bit_cnt != '0);

    sipo_out_buf #(
        .N(N)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .load       (complete),
        .word       (sr_nx),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: directed cases with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_sipo_rx;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         direction = 1'b0;
    logic         din = 1'b0;
    logic         din_valid = 1'b0;
    logic [N-1:0] dout;
    logic         dout_valid;
    logic         dout_ready = 1'b1;
    logic         busy;
    logic [1:0]   bit_cnt;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    sipo_rx #(
        .N(N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .direction  (direction),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .bit_cnt    (bit_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: collected bits in a queue, word built by index.
    bit           mq[$];
    logic         m_dir;
    logic [N-1:0] m_dout;
    logic [N-1:0] m_word;
    logic         m_valid;
    logic         m_ovf;
    logic         m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_dir   = 1'b0;
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else if (clear) begin
            mq.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (din_valid) begin
                if (mq.size() == 0)
                    m_dir = direction;
                mq.push_back(din);
                if (mq.size() == N) begin
                    for (int i = 0; i < N; i++) begin
                        if (m_dir)
                            m_word[N-1-i] = mq[i];
                        else
                            m_word[i] = mq[i];
                    end
                    mq.delete();
                    m_done = 1'b1;
                end
            end
            if (m_done) begin
                if (!m_valid || dout_ready) begin
                    m_dout  = m_word;
                    m_valid = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_valid && dout_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mon_valid", dout_valid, m_valid);
            chk("mon_overflow", overflow, m_ovf);
            chk("mon_bit_cnt", bit_cnt, mq.size());
            chk("mon_busy", busy, mq.size() != 0);
            if (m_valid)
                chk("mon_dout", dout, m_dout);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic d);
        din       = b;
        direction = d;
        din_valid = 1'b1;
        step(1);
        din_valid = 1'b0;
    endtask

    task automatic send_word(input logic [N-1:0] w, input logic d);
        for (int i = N - 1; i >= 0; i--)
            send_bit(w[i], d);
    endtask

    task automatic drain();
        dout_ready = 1'b1;
        step(2);
    endtask

    initial begin
        step(3);
        chk("rst_dout", dout, 4'b0000);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_cnt", bit_cnt, 2'd0);
        rst = 1'b0;
        step(2);

        // MSB-first 1011, one-cycle valid pulse with ready high
        send_word(4'b1011, 1'b1);
        chk("t1_valid", dout_valid, 1'b1);
        chk("t1_dout", dout, 4'b1011);
        step(1);
        chk("t1_valid_fall", dout_valid, 1'b0);

        // LSB-first 1,0,1,1
        send_word(4'b1011, 1'b0);
        chk("t2_dout", dout, 4'b1101);
        drain();

        // direction flip mid-word is ignored
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        chk("t2b_dout", dout, 4'b1101);
        drain();

        // gaps between bits
        send_bit(1'b1, 1'b1);
        step(3);
        chk("t3_cnt1", bit_cnt, 2'd1);
        chk("t3_busy1", busy, 1'b1);
        send_bit(1'b1, 1'b0);
        step(3);
        send_bit(1'b0, 1'b0);
        step(3);
        chk("t3_cnt3", bit_cnt, 2'd3);
        chk("t3_busy3", busy, 1'b1);
        send_bit(1'b0, 1'b0);
        chk("t3_dout", dout, 4'b1100);
        chk("t3_busy0", busy, 1'b0);
        drain();

        // overflow under backpressure
        dout_ready = 1'b0;
        send_word(4'b1011, 1'b1);
        send_word(4'b0110, 1'b1);
        chk("t4_dout", dout, 4'b1011);
        chk("t4_ovf", overflow, 1'b1);
        dout_ready = 1'b1;
        step(1);
        chk("t4_valid", dout_valid, 1'b0);
        chk("t4_ovf_sticky", overflow, 1'b1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("t4_ovf_clr", overflow, 1'b0);

        // simultaneous consume and refill
        dout_ready = 1'b0;
        send_word(4'b1011, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        dout_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        chk("t5_dout", dout, 4'b0101);
        chk("t5_valid", dout_valid, 1'b1);
        chk("t5_ovf", overflow, 1'b0);
        drain();

        // async reset mid-word
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_cnt", bit_cnt, 2'd0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_dout", dout, 4'b0000);
        chk("t6_rst_valid", dout_valid, 1'b0);
        #1;
        rst = 1'b0;
        step(1);
        send_word(4'b0110, 1'b1);
        chk("t6_dout", dout, 4'b0110);
        drain();

        // clear mid-word
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("t6c_cnt", bit_cnt, 2'd0);
        send_word(4'b0110, 1'b1);
        chk("t6c_dout", dout, 4'b0110);
        drain();

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            din_valid  = ($urandom % 3) != 0;
            din        = 1'($urandom % 2);
            direction  = 1'($urandom % 2);
            dout_ready = ($urandom % 3) != 0;
            clear      = ($urandom % 40) == 0;
            step(1);
        end
        din_valid = 1'b0;
        clear     = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
